// File: rtl/stage_id_hazard_pkg.sv
// Shared pipeline definitions: operand-mux select encodings and the
// destination-register shadow payload carried down EX and MEM.
package stage_id_hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_RF   = 2'd0;
  localparam logic [SEL_W-1:0] SEL_EALU = 2'd1;
  localparam logic [SEL_W-1:0] SEL_MALU = 2'd2;
  localparam logic [SEL_W-1:0] SEL_MMO  = 2'd3;

  typedef struct packed {
    logic             wreg;
    logic             m2reg;
    logic [REG_W-1:0] rn;
  } shadow_t;

  localparam shadow_t BUBBLE = '{wreg: 1'b0, m2reg: 1'b0, rn: '0};

  // r0 is hard-wired zero, so a write to it never becomes a forwarding source.
  function automatic shadow_t make_shadow(input logic wreg, input logic m2reg,
                                          input logic [REG_W-1:0] rn);
    shadow_t s;
    s.wreg  = wreg && (rn != '0);
    s.m2reg = m2reg;
    s.rn    = rn;
    return s;
  endfunction

endpackage

// File: rtl/stage_id_hazard_fwd_pick.sv
// Bypass decision for one ID source register against the EX and MEM shadows.
module fwd_pick
  import stage_id_hazard_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [REG_W-1:0] ex_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [REG_W-1:0] mem_rn,
  output logic [SEL_W-1:0] sel,
  output logic             hazard
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_wreg  && (ex_rn  == src);
  assign mem_hit = mem_wreg && (mem_rn == src);

  // Youngest producer wins; a load still in EX cannot be bypassed yet.
  always_comb begin
    sel    = SEL_RF;
    hazard = 1'b0;
    if (!use_src || (src == '0)) begin
      sel = SEL_RF;
    end else if (ex_hit) begin
      if (ex_m2reg) hazard = 1'b1;
      else          sel    = SEL_EALU;
    end else if (mem_hit) begin
      sel = mem_m2reg ? SEL_MMO : SEL_MALU;
    end
  end

endmodule

// File: rtl/stage_id_hazard.sv
// Forwarding and load-use hazard control for the ID stage: tracks EX/MEM
// destination shadows and drives the operand-mux selects and stall.
module stage_id_hazard
  import stage_id_hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_0,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_flush,
  input  logic             hold,
  output logic [SEL_W-1:0] a_select,
  output logic [SEL_W-1:0] b_select,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  shadow_t ex_q;
  shadow_t mem_q;
  shadow_t ex_d;
  logic    hazard_a;
  logic    hazard_b;

  fwd_pick u_pick_rs (
    .src       (id_rs),
    .use_src   (id_use_rs),
    .ex_wreg   (ex_q.wreg),
    .ex_m2reg  (ex_q.m2reg),
    .ex_rn     (ex_q.rn),
    .mem_wreg  (mem_q.wreg),
    .mem_m2reg (mem_q.m2reg),
    .mem_rn    (mem_q.rn),
    .sel       (a_select),
    .hazard    (hazard_a)
  );

  fwd_pick u_pick_rt (
    .src       (id_rt),
    .use_src   (id_use_rt),
    .ex_wreg   (ex_q.wreg),
    .ex_m2reg  (ex_q.m2reg),
    .ex_rn     (ex_q.rn),
    .mem_wreg  (mem_q.wreg),
    .mem_m2reg (mem_q.m2reg),
    .mem_rn    (mem_q.rn),
    .sel       (b_select),
    .hazard    (hazard_b)
  );

  // A killed instruction or a frozen pipeline never costs a stall cycle.
  assign stall = (hazard_a || hazard_b) && !id_flush && !hold;

  always_comb begin
    ex_d = make_shadow(id_wreg, id_m2reg, id_rn);
    if (stall || id_flush) ex_d = BUBBLE;
  end

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      stall_count <= '0;
    end else if (!hold) begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      if (stall && (stall_count != CNT_MAX)) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
